// File: rtl/throw_capture_display.sv
// throw_capture_display
//   Downstream stage of the dice / traffic-light mux. In dice mode it follows
//   a roll while the button is held. After release it waits a settle window
//   and then captures the final throw. It keeps a per-face histogram and
//   drives a 7-segment display. In lights mode the {red,amber,green} bits of
//   `result` are mapped directly onto segments a/g/d.
//
// Optional feature (macro THROW_CAPTURE_DISPLAY_BLINK_EN):
//   When defined, the digit blinks while ROLLING. The blink has a half-period
//   of BLINK_CYC cycles. When undefined, ROLLING shows the live digit.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   sel       in   0 = dice mode, 1 = traffic-light mode
//   button    in   roll button, high = rolling
//   result    in   [2:0] mux output
//   hist_clr  in   one-cycle pulse: clear histogram, total and illegal
//   rd_face   in   [2:0] face (1..6) to read from the histogram
//   seg       out  [6:0] {g,f,e,d,c,b,a}, active-high, registered
//   held      out  [2:0] last captured throw
//   valid     out  high while a fresh capture is displayed (HOLD)
//   illegal   out  sticky flag: a capture saw 0 or 7
//   rd_count  out  [COUNT_W-1:0] registered histogram read
//   total     out  [COUNT_W-1:0] saturating count of legal captures
module throw_capture_display #(
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned COUNT_W    = 8,
    parameter int unsigned BLINK_CYC  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sel,
    input  logic               button,
    input  logic [2:0]         result,
    input  logic               hist_clr,
    input  logic [2:0]         rd_face,
    output logic [6:0]         seg,
    output logic [2:0]         held,
    output logic               valid,
    output logic               illegal,
    output logic [COUNT_W-1:0] rd_count,
    output logic [COUNT_W-1:0] total
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROLLING,
        S_SETTLE,
        S_HOLD,
        S_LIGHTS
    } state_t;

    localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    state_t               r_state, w_next;
    logic [SW-1:0]        r_settle;
    logic                 w_capture, w_settle_clr, w_settle_inc;
    logic                 w_legal;
    logic [2:0]           r_held;
    logic                 r_valid, r_illegal;
    logic [COUNT_W-1:0]   r_face [6];
    logic [COUNT_W-1:0]   r_total, r_rd_count, w_rd;
    logic [6:0]           r_seg, w_seg_src, w_live, w_held_dig;
    logic                 w_blink;

    function automatic logic [6:0] f_digit(input logic [2:0] v);
        case (v)
            3'd1:    f_digit = 7'h06;
            3'd2:    f_digit = 7'h5B;
            3'd3:    f_digit = 7'h4F;
            3'd4:    f_digit = 7'h66;
            3'd5:    f_digit = 7'h6D;
            3'd6:    f_digit = 7'h7D;
            default: f_digit = 7'h40;
        endcase
    endfunction

    assign w_legal    = (result != 3'd0) && (result != 3'd7);
    assign w_live     = f_digit(result);
    assign w_held_dig = f_digit(r_held);

    // Next-state logic. sel overrides every state and also overrides the button.
    always_comb begin
        w_next       = r_state;
        w_capture    = 1'b0;
        w_settle_clr = 1'b0;
        w_settle_inc = 1'b0;
        if (sel) begin
            w_next = S_LIGHTS;
        end else begin
            unique case (r_state)
                S_IDLE:    if (button) w_next = S_ROLLING;
                S_ROLLING: if (!button) begin
                    w_next       = S_SETTLE;
                    w_settle_clr = 1'b1;
                end
                S_SETTLE: begin
                    if (button) begin
                        w_next = S_ROLLING;
                    end else if (r_settle == SETTLE_LAST) begin
                        w_next    = S_HOLD;
                        w_capture = 1'b1;
                    end else begin
                        w_settle_inc = 1'b1;
                    end
                end
                S_HOLD:    if (button) w_next = S_ROLLING;
                S_LIGHTS:  w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_settle <= '0;
        end else begin
            r_state <= w_next;
            if (w_settle_clr)
                r_settle <= '0;
            else if (w_settle_inc)
                r_settle <= r_settle + 1'b1;
        end
    end

    // Capture register and the valid flag. valid is cleared when the FSM
    // leaves HOLD, either on a re-press or on a switch to lights mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_held  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_capture)
                r_held <= result;
            if (sel)
                r_valid <= 1'b0;
            else if (w_capture)
                r_valid <= 1'b1;
            else if (r_state == S_HOLD && button)
                r_valid <= 1'b0;
        end
    end

    // Histogram accounting. When a clear and a capture arrive together, the
    // clear wins.
    always_ff @(posedge clk) begin
        if (rst || hist_clr) begin
            for (int unsigned i = 0; i < 6; i++)
                r_face[i] <= '0;
            r_total   <= '0;
            r_illegal <= 1'b0;
        end else if (w_capture) begin
            if (w_legal) begin
                for (int unsigned i = 0; i < 6; i++)
                    if (result == 3'(i + 1) && r_face[i] != '1)
                        r_face[i] <= r_face[i] + 1'b1;
                if (r_total != '1)
                    r_total <= r_total + 1'b1;
            end else begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rd = '0;
        for (int unsigned i = 0; i < 6; i++)
            if (rd_face == 3'(i + 1))
                w_rd = r_face[i];
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_rd_count <= '0;
        else
            r_rd_count <= w_rd;
    end

`ifdef THROW_CAPTURE_DISPLAY_BLINK_EN
    localparam int unsigned BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [BW-1:0] PHASE_LAST = BW'(BLINK_CYC - 1);

    logic [BW-1:0] r_phase;
    logic          r_blink;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
            r_blink <= 1'b0;
        end else if (r_phase == PHASE_LAST) begin
            r_phase <= '0;
            r_blink <= ~r_blink;
        end else begin
            r_phase <= r_phase + 1'b1;
        end
    end

    assign w_blink = r_blink;
`else
    // Without blinking, ROLLING always shows the digit. BLINK_CYC is at least 1.
    assign w_blink = (BLINK_CYC != 0);
`endif

    always_comb begin
        w_seg_src = 7'h40;
        unique case (r_state)
            S_IDLE:    w_seg_src = 7'h40;
            S_ROLLING: w_seg_src = w_blink ? w_live : 7'h00;
            S_SETTLE:  w_seg_src = w_live;
            S_HOLD:    w_seg_src = w_held_dig;
            S_LIGHTS:  w_seg_src = {result[1], 2'b00, result[0], 2'b00, result[2]};
            default:   w_seg_src = 7'h40;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_seg <= '0;
        else
            r_seg <= w_seg_src;
    end

    assign seg      = r_seg;
    assign held     = r_held;
    assign valid    = r_valid;
    assign illegal  = r_illegal;
    assign rd_count = r_rd_count;
    assign total    = r_total;

endmodule

// File: tb/tb_throw_capture_display.sv
module tb_throw_capture_display;

    localparam int SETTLE = 3;
    localparam int CW     = 3;
    localparam int BC     = 4;
    localparam int MAXC   = (1 << CW) - 1;

    // Reference-model modes
    localparam int M_IDLE = 0, M_ROLL = 1, M_SETTLE = 2, M_HOLD = 3, M_LIGHTS = 4;

    logic          clk = 1'b0;
    logic          rst, sel, button, hist_clr;
    logic [2:0]    result, rd_face;
    logic [6:0]    seg;
    logic [2:0]    held;
    logic          valid, illegal;
    logic [CW-1:0] rd_count, total;

    always #5 clk = ~clk;

    throw_capture_display #(
        .SETTLE_CYC (SETTLE),
        .COUNT_W    (CW),
        .BLINK_CYC  (BC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .button   (button),
        .result   (result),
        .hist_clr (hist_clr),
        .rd_face  (rd_face),
        .seg      (seg),
        .held     (held),
        .valid    (valid),
        .illegal  (illegal),
        .rd_count (rd_count),
        .total    (total)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Behavioural model state
    int m_mode, m_since, m_total, m_held, m_seg, m_rd, m_age;
    int m_hist [8];
    bit m_valid, m_illegal;

    function automatic int digit(input int v);
        case (v)
            1: return 'h06;
            2: return 'h5B;
            3: return 'h4F;
            4: return 'h66;
            5: return 'h6D;
            6: return 'h7D;
            default: return 'h40;
        endcase
    endfunction

    task automatic model_step();
        bit cap;
        bit blink_on;
        int r;
        r = int'(result);
        if (rst) begin
            m_mode = M_IDLE; m_since = 0; m_total = 0; m_held = 0; m_seg = 0;
            m_rd = 0; m_age = 0; m_valid = 0; m_illegal = 0;
            foreach (m_hist[i]) m_hist[i] = 0;
            return;
        end
        // The blink is 0 for BC edges after reset, then 1 for BC edges, and so on.
        blink_on = ((m_age / BC) % 2) == 1;
        case (m_mode)
            M_IDLE:   m_seg = 'h40;
`ifdef THROW_CAPTURE_DISPLAY_BLINK_EN
            M_ROLL:   m_seg = blink_on ? digit(r) : 0;
`else
            M_ROLL:   m_seg = digit(r);
`endif
            M_SETTLE: m_seg = digit(r);
            M_HOLD:   m_seg = digit(m_held);
            default:  m_seg = (int'(result[1]) << 6) | (int'(result[0]) << 3) | int'(result[2]);
        endcase
        m_rd = (rd_face >= 1 && rd_face <= 6) ? m_hist[rd_face] : 0;
        m_age++;
        cap = 0;
        if (sel) begin
            m_mode = M_LIGHTS; m_valid = 0;
        end else begin
            case (m_mode)
                M_IDLE:   if (button) m_mode = M_ROLL;
                M_LIGHTS: m_mode = M_IDLE;
                M_ROLL:   if (!button) begin m_mode = M_SETTLE; m_since = 0; end
                M_SETTLE: begin
                    if (button) m_mode = M_ROLL;
                    else if (m_since == SETTLE - 1) begin
                        cap = 1; m_held = r; m_valid = 1; m_mode = M_HOLD;
                    end else m_since++;
                end
                default:  if (button) begin m_mode = M_ROLL; m_valid = 0; end
            endcase
        end
        if (hist_clr) begin
            foreach (m_hist[i]) m_hist[i] = 0;
            m_total = 0; m_illegal = 0;
        end else if (cap) begin
            if (r >= 1 && r <= 6) begin
                if (m_hist[r] < MAXC) m_hist[r]++;
                if (m_total < MAXC) m_total++;
            end else m_illegal = 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        check_eq("seg",      32'(seg),      32'(m_seg));
        check_eq("held",     32'(held),     32'(m_held));
        check_eq("valid",    32'(valid),    32'(m_valid));
        check_eq("illegal",  32'(illegal),  32'(m_illegal));
        check_eq("rd_count", 32'(rd_count), 32'(m_rd));
        check_eq("total",    32'(total),    32'(m_total));
    endtask

    // Hold the button for two cycles, then release it for SETTLE+1 edges. The
    // last of those edges is the capture edge.
    task automatic do_capture(input logic [2:0] v, input bit clr_at_capture);
        button = 1'b1; result = v;
        cycle(); cycle();
        button = 1'b0;
        for (int k = 0; k <= SETTLE; k++) begin
            hist_clr = clr_at_capture && (k == SETTLE);
            cycle();
        end
        hist_clr = 1'b0;
        check_eq("cap_held",  32'(held),  32'(v));
        check_eq("cap_valid", 32'(valid), 32'd1);
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; button = 1'b0; hist_clr = 1'b0;
        result = 3'd0; rd_face = 3'd0;
        cycle(); cycle();
        rst = 1'b0;
        for (int f = 0; f < 8; f++) begin
            rd_face = 3'(f);
            cycle();
        end

        // Basic capture of a 3, followed by a read of face 3
        rd_face = 3'd3;
        do_capture(3'd3, 1'b0);
        cycle(); cycle();
        check_eq("total_after_3", 32'(total), 32'd1);
        check_eq("rd3_after_3",   32'(rd_count), 32'd1);

        // Re-press during the settle window: no capture
        button = 1'b1; cycle(); cycle();
        button = 1'b0; cycle(); cycle();
        button = 1'b1; cycle(); cycle();
        check_eq("abort_total", 32'(total), 32'd1);

        // Switch to lights mode while settling
        button = 1'b0; cycle();
        sel = 1'b1; result = 3'b100; cycle(); cycle();
        check_eq("lights_red", 32'(seg), 32'h01);
        sel = 1'b0; cycle(); cycle();
        check_eq("idle_dash", 32'(seg), 32'h40);

        // Illegal capture of 7, then clear
        do_capture(3'd7, 1'b0);
        cycle();
        check_eq("ill_flag", 32'(illegal), 32'd1);
        check_eq("ill_seg",  32'(seg),     32'h40);
        hist_clr = 1'b1; cycle(); hist_clr = 1'b0; cycle();
        check_eq("ill_clr",  32'(illegal), 32'd0);

        // Saturation of face 6, then a clear that lands on a capture edge
        rd_face = 3'd6;
        for (int i = 0; i < MAXC + 2; i++) do_capture(3'd6, 1'b0);
        cycle();
        check_eq("sat6", 32'(rd_count), 32'(MAXC));
        do_capture(3'd6, 1'b1);
        cycle();
        check_eq("race_total", 32'(total),    32'd0);
        check_eq("race_rd6",   32'(rd_count), 32'd0);

        // Randomised stimulus
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0)   button = ~button;
            if ($urandom_range(0, 79) == 0)  sel = ~sel;
            rst      = ($urandom_range(0, 999) == 0);
            hist_clr = ($urandom_range(0, 199) == 0);
            result   = 3'($urandom_range(0, 7));
            rd_face  = 3'($urandom_range(0, 7));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/throw_capture_display.md
Name: throw_capture_display

Overview:
- Downstream stage of the dice/traffic-light mux. Consumes the 3-bit `result`.
- Dice mode:
  - Tracks the roll as `button` is held and released.
  - Waits a settle window, then captures the final throw.
  - Keeps a per-face histogram and drives a 7-segment display.
- Lights mode: maps `result` directly onto display segments and leaves capture logic untouched.

Parameters:
- SETTLE_CYC, 4: cycles spent in SETTLE before capture (≥1).
- COUNT_W, 8: width of histogram and total counters.
- BLINK_CYC, 8: half-period in cycles of the rolling blink (used only with BLINK_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- sel  in  1  0 = dice mode, 1 = traffic-light mode (same select as the mux).
- button  in  1  dice roll button; high = rolling.
- result  in  3  mux output; in lights mode it is {red,amber,green} = result[2:0].
- hist_clr  in  1  one-cycle pulse; clears histogram and total.
- rd_face  in  3  face (1..6) to read from the histogram.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high, registered.
- held  out  3  last captured throw.
- valid  out  1  high while `held` is a fresh capture being displayed (HOLD state).
- illegal  out  1  sticky; set when a capture sees 0 or 7.
- rd_count  out  COUNT_W  histogram count for rd_face, registered.
- total  out  COUNT_W  number of legal captures, saturating.

Behaviour:
- Reset (sync, at clk edge with rst=1):
  - state = IDLE; seg = 7'h00; held = 0; valid = 0; illegal = 0; rd_count = 0; total = 0.
  - All six face counters cleared. rst mid-operation aborts any pending capture.
- FSM states: IDLE, ROLLING, SETTLE, HOLD, LIGHTS.
  - sel=1 from any state → LIGHTS at the next edge. Any pending capture is aborted; valid = 0; held and counters are unchanged.
  - LIGHTS with sel=0 → IDLE.
  - IDLE: button=1 → ROLLING.
  - ROLLING: button=0 sampled at edge E0 → SETTLE, settle counter = 0.
  - SETTLE:
    - button=1 → ROLLING, no capture.
    - Otherwise the counter increments each edge. At the edge where counter == SETTLE_CYC-1: held = result, valid = 1, → HOLD.
    - Net effect: capture occurs at edge E0+SETTLE_CYC.
  - HOLD: button=1 → ROLLING and valid = 0. Otherwise stay.
- Capture accounting:
  - Captured value 1..6: increment face counter and total, each saturating at 2^COUNT_W-1.
  - Captured value 0 or 7: no increment; illegal = 1. illegal clears only on rst or hist_clr.
- hist_clr: zeros all face counters, total and illegal at the next edge. If a capture lands in the same cycle, clear wins and the increment is dropped; held/valid still update.
- rd_count:
  - Registered one-cycle read: rd_count at edge N+1 = counter[rd_face sampled at edge N].
  - rd_face 0 or 7 → 0.
  - Reflects the post-update value one cycle after an increment.
- Digit decode, 7'h values: 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D; 0 and 7 → 40 (dash).
- seg source per state, one-cycle registered latency from the source:
  - IDLE: 7'h40.
  - ROLLING / SETTLE: decode of live result.
  - HOLD: decode of held.
  - LIGHTS: a = result[2] (red), g = result[1] (amber), d = result[0] (green); other segments 0.
- Simultaneous button=1 and sel=1: sel wins.

Optional Feature:
- Macro: THROW_CAPTURE_DISPLAY_BLINK_EN.
- Defined:
  - A free-running phase counter toggles a blink bit every BLINK_CYC cycles; reset clears the bit to 0.
  - In ROLLING only, seg = 7'h00 while the blink bit is 0 and shows the live digit while it is 1.
  - SETTLE, HOLD, IDLE and LIGHTS are unaffected.
- Undefined: no blink logic; ROLLING shows the live digit every cycle.

Test Plan:
- Reset: rst=1 for 2 cycles → seg=00, valid=0, held=0, total=0, rd_count=0 for every face.
- Capture: sel=0, button=1 for 10 cycles, result settles at 3, button drops at E0 → valid=1 and held=3 at E0+4, seg=4F, total=1; rd_face=3 → rd_count=1 the next cycle.
- Abort:
  - Re-press at E0+2 → back to ROLLING, no capture, total unchanged.
  - sel=1 during SETTLE → LIGHTS; result=3'b100 → seg=01; after sel=0 → IDLE, seg=40.
- Illegal: capture with result=7 → held=7, seg=40, illegal=1, total unchanged; hist_clr pulse → illegal=0.
- Saturation / clear race: COUNT_W=2, four captures of 6 → face-6 count=3, total=3. hist_clr coinciding with a fifth capture → count=0, total=0, held=6, valid=1.
- BLINK_EN, BLINK_CYC=8: hold button with result=2 for 32 cycles → seg alternates 00 / 5B in runs of 8 cycles.
